// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter and return-address stage of the Gumnut core.
// Registers the fetch address and applies the control unit's PC operation code.
// Holds a circular return-address stack of STACK_DEPTH entries.
// Holds a single-level interrupt save register for the PC and the Z/C flags.
// Optional macro PC_STACK_ERR_EN builds the sticky stack overflow/underflow flags.
// Without that macro, both flags are tied low and err_clr_i is ignored.
module pc_stack_unit #(
  parameter int              PC_W         = 12,
  parameter int              STACK_DEPTH  = 8,
  parameter logic [PC_W-1:0] RESET_VECTOR = '0,
  parameter logic [PC_W-1:0] INT_VECTOR   = PC_W'(1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_en_i,
  input  logic [3:0]      pc_oper_i,
  input  logic            jsb_i,
  input  logic            ret_i,
  input  logic            reti_i,
  input  logic            int_i,
  input  logic [7:0]      disp_i,
  input  logic [PC_W-1:0] addr_i,
  input  logic            zero_i,
  input  logic            carry_i,
  output logic [PC_W-1:0] pc_o,
  output logic            int_active_o,
  output logic            restore_o,
  output logic            int_z_o,
  output logic            int_c_o,
  output logic            stack_ovf_o,
  output logic            stack_unf_o,
  input  logic            err_clr_i
);

  localparam int SP_W  = $clog2(STACK_DEPTH);
  localparam int CNT_W = SP_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(STACK_DEPTH);

  localparam logic [3:0] OP_INC  = 4'h0;
  localparam logic [3:0] OP_INT  = 4'h1;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_RET  = 4'hA;
  localparam logic [3:0] OP_RETI = 4'hC;

  logic [PC_W-1:0]  pc_q, pc_nxt, pc_inc, disp_ext;
  logic [PC_W-1:0]  int_pc_q;
  logic             int_z_q, int_c_q, int_active_q, restore_q;
  logic [SP_W-1:0]  sp_q, sp_dec;
  logic [CNT_W-1:0] cnt_q;
  logic [PC_W-1:0]  stack_q [STACK_DEPTH];
  logic             br_taken, push, pop, int_entry, reti;
  logic             stack_full, stack_empty;

  // The ret/reti/int strobes only duplicate information already in pc_oper_i.
  // The operation code alone drives the decode, so these strobes are left unconnected.
  logic unused_xchk;
  assign unused_xchk = ^{ret_i, reti_i, int_i};

  assign pc_inc      = pc_q + PC_W'(1);
  assign disp_ext    = {{(PC_W-8){disp_i[7]}}, disp_i};
  assign sp_dec      = sp_q - SP_W'(1);
  assign stack_full  = (cnt_q == CNT_FULL);
  assign stack_empty = (cnt_q == '0);

  // Branch condition select from the low two bits of the operation code
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    br_taken = 1'b0;
    case (pc_oper_i[1:0])
      2'd0: br_taken = zero_i;
      2'd1: br_taken = ~zero_i;
      2'd2: br_taken = carry_i;
      2'd3: br_taken = ~carry_i;
      default: br_taken = 1'b0;
    endcase
  end

  // Decode the PC operation into the next PC and the stack/interrupt strobes
  always_comb begin
    pc_nxt    = pc_q;
    push      = 1'b0;
    pop       = 1'b0;
    int_entry = 1'b0;
    reti      = 1'b0;
    if (pc_en_i) begin
      case (pc_oper_i)
        OP_INC:  pc_nxt = pc_inc;
        OP_INT: begin
          pc_nxt    = INT_VECTOR;
          int_entry = 1'b1;
        end
        4'h4, 4'h5, 4'h6, 4'h7:
          pc_nxt = br_taken ? (pc_inc + disp_ext) : pc_inc;
        OP_JMP: begin
          pc_nxt = addr_i;
          push   = jsb_i;
        end
        OP_RET: begin
          pc_nxt = stack_q[sp_dec];
          pop    = 1'b1;
        end
        OP_RETI: begin
          pc_nxt = int_pc_q;
          reti   = 1'b1;
        end
        default: pc_nxt = pc_q;
      endcase
    end
  end

  // PC, interrupt save register, flag restore pulse, stack pointer and fill count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_VECTOR;
      int_pc_q     <= '0;
      int_z_q      <= 1'b0;
      int_c_q      <= 1'b0;
      int_active_q <= 1'b0;
      restore_q    <= 1'b0;
      sp_q         <= '0;
      cnt_q        <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
      pc_q      <= pc_nxt;
      restore_q <= reti;
      if (int_entry) begin
        int_pc_q     <= pc_q;
        int_z_q      <= zero_i;
        int_c_q      <= carry_i;
        int_active_q <= 1'b1;
      end else if (reti) begin
        int_active_q <= 1'b0;
      end
      if (push) begin
        sp_q <= sp_q + SP_W'(1);
        if (!stack_full) cnt_q <= cnt_q + CNT_W'(1);
      end else if (pop) begin
        sp_q <= sp_dec;
        if (!stack_empty) cnt_q <= cnt_q - CNT_W'(1);
      end
    end
  end

  // Return-address storage: a push writes the slot at the current stack pointer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the stack is a flop array with a defined reset value, because a pop right after reset must return zero.
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (push) begin
      stack_q[sp_q] <= pc_inc;
    end
  end

`ifdef PC_STACK_ERR_EN
  logic ovf_q, unf_q;

  // Sticky error flags: a new error event takes priority over err_clr_i
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= (push & stack_full)  | (ovf_q & ~err_clr_i);
      unf_q <= (pop  & stack_empty) | (unf_q & ~err_clr_i);
    end
  end

  assign stack_ovf_o = ovf_q;
  assign stack_unf_o = unf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign stack_ovf_o    = 1'b0;
  assign stack_unf_o    = 1'b0;
`endif

  assign pc_o         = pc_q;
  assign int_active_o = int_active_q;
  assign restore_o    = restore_q;
  assign int_z_o      = int_z_q;
  assign int_c_o      = int_c_q;

endmodule
